hc595_frame_rx: RTL and testbench
=================================

# hc595_frame_rx

Serial-to-parallel receiver for the 74HC595 display link (ds/shcp/stcp/oe). It samples the external pins on the 50 MHz system clock and reassembles each 16-bit frame into 8-bit digit-select and segment-select words for an 8-digit common-anode display. It also flags malformed frames and reports a lost link. It serves as the on-board loopback monitor for the display driver and as the front end of a slave board that shows the same display.

## Interface
- TIMEOUT_CYC, 1_000_000: sclk cycles without a valid frame before link_lost asserts (20 ms at 50 MHz); legal range 2..2^24-1.
- sclk  in  1  system clock, 50 MHz
- nrst  in  1  reset, asynchronous, active-low
- ds  in  1  serial data pin, asynchronous to sclk
- shcp  in  1  shift clock pin, rising edge shifts, asynchronous
- stcp  in  1  storage clock pin, rising edge latches, asynchronous
- oe  in  1  output-enable pin, active-low, asynchronous
- sel  out  8  latched digit select, [7]=DIG_7 .. [0]=DIG_0
- seg  out  8  latched segment select, [7]=DP,[6]=G .. [0]=A
- disp_en  out  1  synchronized ~oe
- frame_valid  out  1  one-cycle pulse when a good frame updates sel/seg
- frame_err  out  1  one-cycle pulse when stcp arrives with a shift count other than 16
- link_lost  out  1  high while no good frame has been seen for TIMEOUT_CYC cycles

## Operation
- Synchronization: ds, shcp, stcp and oe each pass through two flops (s1, s2). shcp and stcp have a third flop (s3). rise = s2 & ~s3. ds uses its s2 value, so it is aligned with the shcp edge.
- Shift: on shcp rise, sr[15:0] <= {sr[14:0], ds_s2}; the first bit received ends up in sr[15]. shift_cnt (5 bits) increments and saturates at 31.
- Wire order of a frame: sel[7], sel[6] .. sel[0], then seg[7] .. seg[0]. At a good latch, sel <= sr[15:8] and seg <= sr[7:0].
- Latch on stcp rise:
  - If shift_cnt == 16: update sel/seg, pulse frame_valid, clear the timeout counter and link_lost.
  - Otherwise: sel/seg hold their values and frame_err pulses.
  - In both cases shift_cnt clears to 0. sr is not cleared.
- Simultaneous shcp rise and stcp rise in the same cycle: the latch uses the pre-shift sr and pre-shift shift_cnt, matching a 74HC595 with tied clocks. Afterwards shift_cnt = 1 and the new bit is in sr[0].
- Timeout: a 24-bit counter increments every cycle and saturates. When it reaches TIMEOUT_CYC-1, link_lost is set; it clears only on frame_valid.
- disp_en = ~oe_s2. The block does not gate sel/seg with disp_en.
- The link has no framing start bit. The first frame after reset or after an error is accepted only if exactly 16 shifts precede stcp.

## Timing
- Reset values:
  - sel = 8'h00, seg = 8'hFF (all segments off).
  - frame_valid = 0, frame_err = 0.
  - link_lost = 1 (no frame yet), disp_en = 0.
  - sr = 0, shift_cnt = 0, timeout counter = 0, all sync flops = 0.
- Latency: let k be the first sclk rising edge that samples stcp high. sel/seg/frame_valid/frame_err update at edge k+2, and the pulse is high for exactly one cycle. link_lost clears at the same edge k+2. disp_en follows oe with 2 cycles of latency.
- Input requirements:
  - shcp and stcp high and low widths ≥ 2 sclk each.
  - ds stable from 2 sclk before to 1 sclk after the shcp pin rising edge.
  - The shortest nominal frame is 4 sclk per bit, i.e. 64 sclk per frame.
- Asynchronous reset mid-frame: all state returns to reset values immediately. A partial frame is discarded, and the next stcp yields frame_err unless 16 fresh shifts occur first.
- frame_valid and frame_err are never high in the same cycle.

## Test plan
- Nominal frame: sel=8'hFE, seg=8'hC0 sent at 4 sclk/bit followed by stcp -> sel=FE, seg=C0, a single frame_valid pulse at k+2, frame_err=0, link_lost falls to 0.
- Back-to-back frames sent continuously (FE/C0 then FD/F9, 64 cycles/frame) -> two frame_valid pulses exactly 64 cycles apart, with the expected values after each.
- Short frame (12 shifts) and long frame (20 shifts) -> frame_err pulses each time; sel/seg keep the previous FE/C0. A following 16-bit frame 7F/80 is accepted.
- Tied clocks (shcp and stcp driven as the same waveform) with 17 edges -> the 17th edge latches the first 16 bits; shift_cnt reads 1 afterwards.
- Timeout with TIMEOUT_CYC=200: a good frame, then idle -> link_lost rises 200 cycles after frame_valid; the next good frame clears it at k+2.
- nrst pulsed low after 8 shifts, then stcp -> outputs at reset values, stcp gives frame_err, and sel/seg stay 00/FF.

Source files
------------

// File: rtl/hc595_frame_rx.sv
// Receiver for the 74HC595 display link: synchronizes ds/shcp/stcp/oe to sclk,
// rebuilds 16-bit frames into digit/segment words and watches link health.
module hc595_frame_rx #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       ds,
    input  logic       shcp,
    input  logic       stcp,
    input  logic       oe,
    output logic [7:0] sel,
    output logic [7:0] seg,
    output logic       disp_en,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       link_lost
);

    localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYC - 1);
    localparam logic [4:0]  FRAME_LEN = 5'd16;

    // Saturating increments for the shift counter and the idle counter.
    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    function automatic logic [23:0] sat_inc24(input logic [23:0] v);
        return (v == 24'hFF_FFFF) ? v : v + 24'd1;
    endfunction

    logic        ds_s1_q,   ds_s2_q;
    logic        shcp_s1_q, shcp_s2_q, shcp_s3_q;
    logic        stcp_s1_q, stcp_s2_q, stcp_s3_q;
    // oe is carried inverted so every sync flop resets to 0 with the display off.
    logic        oen_s1_q,  oen_s2_q;

    logic        shcp_rise, stcp_rise;

    logic [15:0] sr_q,     sr_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [7:0]  sel_q,    sel_d;
    logic [7:0]  seg_q,    seg_d;
    logic        fv_q,     fv_d;
    logic        fe_q,     fe_d;
    logic [23:0] tmo_q,    tmo_d;
    logic        lost_q,   lost_d;

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            ds_s1_q   <= 1'b0;
            ds_s2_q   <= 1'b0;
            shcp_s1_q <= 1'b0;
            shcp_s2_q <= 1'b0;
            shcp_s3_q <= 1'b0;
            stcp_s1_q <= 1'b0;
            stcp_s2_q <= 1'b0;
            stcp_s3_q <= 1'b0;
            oen_s1_q  <= 1'b0;
            oen_s2_q  <= 1'b0;
        end else begin
            ds_s1_q   <= ds;
            ds_s2_q   <= ds_s1_q;
            shcp_s1_q <= shcp;
            shcp_s2_q <= shcp_s1_q;
            shcp_s3_q <= shcp_s2_q;
            stcp_s1_q <= stcp;
            stcp_s2_q <= stcp_s1_q;
            stcp_s3_q <= stcp_s2_q;
            oen_s1_q  <= ~oe;
            oen_s2_q  <= oen_s1_q;
        end
    end

    assign shcp_rise = shcp_s2_q & ~shcp_s3_q;
    assign stcp_rise = stcp_s2_q & ~stcp_s3_q;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        seg_d  = seg_q;
        fv_d   = 1'b0;
        fe_d   = 1'b0;
        tmo_d  = sat_inc24(tmo_q);
        lost_d = lost_q | (tmo_q >= TMO_LAST);

        if (shcp_rise) begin
            sr_d  = {sr_q[14:0], ds_s2_q};
            cnt_d = sat_inc5(cnt_q);
        end

        // A latch always judges the pre-shift register, as a 595 with tied clocks does.
        if (stcp_rise) begin
            if (cnt_q == FRAME_LEN) begin
                sel_d  = sr_q[15:8];
                seg_d  = sr_q[7:0];
                fv_d   = 1'b1;
                tmo_d  = 24'd0;
                lost_d = 1'b0;
            end else begin
                fe_d   = 1'b1;
            end
            cnt_d = shcp_rise ? 5'd1 : 5'd0;
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            sr_q   <= 16'h0000;
            cnt_q  <= 5'd0;
            sel_q  <= 8'h00;
            seg_q  <= 8'hFF;
            fv_q   <= 1'b0;
            fe_q   <= 1'b0;
            tmo_q  <= 24'd0;
            lost_q <= 1'b1;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
            fv_q   <= fv_d;
            fe_q   <= fe_d;
            tmo_q  <= tmo_d;
            lost_q <= lost_d;
        end
    end

    assign sel         = sel_q;
    assign seg         = seg_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign link_lost   = lost_q;
    assign disp_en     = oen_s2_q;

endmodule

// File: tb/tb_hc595_frame_rx.sv
// Directed bench for hc595_frame_rx: frames driven bit by bit at 4 sclk/bit,
// expected values written out by hand.
module tb_hc595_frame_rx;

    localparam int unsigned TMO = 200;

    logic       sclk = 1'b0;
    logic       nrst = 1'b0;
    logic       ds   = 1'b0;
    logic       shcp = 1'b0;
    logic       stcp = 1'b0;
    logic       oe   = 1'b1;
    logic [7:0] sel, seg;
    logic       disp_en, frame_valid, frame_err, link_lost;

    hc595_frame_rx #(.TIMEOUT_CYC(TMO)) dut (
        .sclk(sclk), .nrst(nrst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
        .sel(sel), .seg(seg), .disp_en(disp_en), .frame_valid(frame_valid),
        .frame_err(frame_err), .link_lost(link_lost)
    );

    always #10 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Event log sampled on the falling edge.
    int          cyc = 0;
    int          fv_cyc[$];
    logic [15:0] fv_dat[$];
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          ll_rise_cyc = -1;
    logic        ll_prev = 1'b1;

    always @(negedge sclk) begin
        cyc <= cyc + 1;
        if (frame_valid) begin
            fv_cyc.push_back(cyc);
            fv_dat.push_back({sel, seg});
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
        if (link_lost && !ll_prev) ll_rise_cyc <= cyc;
        ll_prev <= link_lost;
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] d, input int n, input bit latch_first);
        for (int i = n - 1; i >= 0; i--) begin
            ds   = d[i];
            shcp = 1'b0;
            if (latch_first && i == n - 1) stcp = 1'b1;
            tick(); tick();
            shcp = 1'b1;
            stcp = 1'b0;
            tick(); tick();
        end
    endtask

    task automatic pulse_stcp(input bit ev, input bit ee, input logic [7:0] es,
                              input logic [7:0] eg, input string tag);
        stcp = 1'b1;
        tick(); tick();
        check({tag, "_k1"}, {frame_valid, frame_err}, 2'b00);
        tick();
        check({tag, "_fv"}, frame_valid, ev);
        check({tag, "_fe"}, frame_err, ee);
        check({tag, "_sel"}, sel, es);
        check({tag, "_seg"}, seg, eg);
        if (ev) check({tag, "_ll"}, link_lost, 1'b0);
        stcp = 1'b0;
        tick();
        check({tag, "_k3"}, {frame_valid, frame_err}, 2'b00);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n0;
        tick(); tick();
        check("rst_sel", sel, 8'h00);
        check("rst_seg", seg, 8'hFF);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_ll", link_lost, 1'b1);
        check("rst_en", disp_en, 1'b0);
        nrst = 1'b1;
        tick();

        oe = 1'b0;
        tick();
        check("en_lat1", disp_en, 1'b0);
        tick();
        check("en_lat2", disp_en, 1'b1);

        // Nominal frame.
        send_bits(32'hFEC0, 16, 1'b0);
        check("nom_ll_pre", link_lost, 1'b1);
        pulse_stcp(1'b1, 1'b0, 8'hFE, 8'hC0, "nom");

        // Short and long frames keep the previous words.
        send_bits(32'h0ABC, 12, 1'b0);
        pulse_stcp(1'b0, 1'b1, 8'hFE, 8'hC0, "short");
        send_bits(32'hA5A5A, 20, 1'b0);
        pulse_stcp(1'b0, 1'b1, 8'hFE, 8'hC0, "long");
        send_bits(32'h7F80, 16, 1'b0);
        pulse_stcp(1'b1, 1'b0, 8'h7F, 8'h80, "after_err");

        // Back-to-back frames, second latch strobes while the next frame starts.
        n0 = fv_cyc.size();
        send_bits(32'hFEC0, 16, 1'b0);
        send_bits(32'hFDF9, 16, 1'b1);
        pulse_stcp(1'b1, 1'b0, 8'hFD, 8'hF9, "b2b");
        check("b2b_count", fv_cyc.size() - n0, 2);
        if (fv_cyc.size() - n0 == 2) begin
            check("b2b_gap", fv_cyc[n0 + 1] - fv_cyc[n0], 64);
            check("b2b_first", fv_dat[n0], 16'hFEC0);
            check("b2b_second", fv_dat[n0 + 1], 16'hFDF9);
        end

        // Simultaneous shift and latch: latch takes the 16 earlier bits, new bit starts a frame.
        send_bits(32'hA55A, 16, 1'b0);
        ds   = 1'b1;
        shcp = 1'b0;
        tick(); tick();
        shcp = 1'b1;
        stcp = 1'b1;
        tick(); tick(); tick();
        check("tied_fv", frame_valid, 1'b1);
        check("tied_fe", frame_err, 1'b0);
        check("tied_sel", sel, 8'hA5);
        check("tied_seg", seg, 8'h5A);
        shcp = 1'b0;
        stcp = 1'b0;
        tick(); tick();
        send_bits(32'h433C, 15, 1'b0);
        pulse_stcp(1'b1, 1'b0, 8'hC3, 8'h3C, "tied_next");

        // Idle until the link is declared lost.
        for (int i = 0; i < 400 && !link_lost; i++) tick();
        tick();
        check("tmo_ll", link_lost, 1'b1);
        check("tmo_gap", ll_rise_cyc - fv_cyc[fv_cyc.size() - 1], TMO);
        send_bits(32'h1234, 16, 1'b0);
        check("tmo_ll_pre", link_lost, 1'b1);
        pulse_stcp(1'b1, 1'b0, 8'h12, 8'h34, "tmo_clear");

        // Reset in the middle of a frame.
        send_bits(32'h00FF, 8, 1'b0);
        nrst = 1'b0;
        #1;
        check("mid_sel", sel, 8'h00);
        check("mid_seg", seg, 8'hFF);
        check("mid_ll", link_lost, 1'b1);
        check("mid_en", disp_en, 1'b0);
        tick();
        nrst = 1'b1;
        tick();
        pulse_stcp(1'b0, 1'b1, 8'h00, 8'hFF, "mid_err");

        check("err_total", err_cnt, 3);
        check("exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
